mcpu_ctrl: RTL and testbench

//  Multi-cycle RV32I control unit: registered FSM that drives PC, IR and memory

---
 rtl/mcpu_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_mcpu_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mcpu_ctrl
// Description : Multi-cycle RV32I control unit (FETCH/DECODE/EXEC/MEM/WB/TRAP)
//               with MIO_ready stall timeout and sticky trap.
//               Define MCPU_UTYPE_EN to make lui/auipc legal.
// Revision    : 1.0 - initial release
// ============================================================================
module mcpu_ctrl #(
    parameter int WAIT_LIMIT = 16,
    parameter int WAIT_W     = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] OPcode,
    input  logic [2:0] Fun3,
    input  logic       Fun7,
    input  logic       Zero,
    input  logic       MIO_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemRW,
    output logic       IorD,
    output logic       RegWrite,
    output logic       ALUSrc_B,
    output logic [1:0] ImmSel,
    output logic [1:0] MemtoReg,
    output logic [1:0] PCSource,
    output logic [3:0] ALU_Control,
    output logic [2:0] state,
    output logic       trap,
    output logic       trap_cause
);

    localparam logic [2:0] c_FETCH  = 3'd0;
    localparam logic [2:0] c_DECODE = 3'd1;
    localparam logic [2:0] c_EXEC   = 3'd2;
    localparam logic [2:0] c_MEM    = 3'd3;
    localparam logic [2:0] c_WB     = 3'd4;
    localparam logic [2:0] c_TRAP   = 3'd7;

    localparam logic [4:0] c_OP_LOAD   = 5'b00000;
    localparam logic [4:0] c_OP_IALU   = 5'b00100;
    localparam logic [4:0] c_OP_AUIPC  = 5'b00101;
    localparam logic [4:0] c_OP_STORE  = 5'b01000;
    localparam logic [4:0] c_OP_RTYPE  = 5'b01100;
    localparam logic [4:0] c_OP_LUI    = 5'b01101;
    localparam logic [4:0] c_OP_BRANCH = 5'b11000;
    localparam logic [4:0] c_OP_JALR   = 5'b11001;
    localparam logic [4:0] c_OP_JAL    = 5'b11011;

    localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

`ifdef MCPU_UTYPE_EN
    localparam logic c_UTYPE_EN = 1'b1;
`else
    localparam logic c_UTYPE_EN = 1'b0;
`endif

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_trap;
    logic              r_trap_cause;

    logic w_is_load, w_is_ialu, w_is_store, w_is_rtype, w_is_branch;
    logic w_is_jal, w_is_jalr, w_is_lui, w_is_auipc, w_legal, w_timeout;

    assign w_is_load   = (OPcode == c_OP_LOAD);
    assign w_is_ialu   = (OPcode == c_OP_IALU);
    assign w_is_store  = (OPcode == c_OP_STORE);
    assign w_is_rtype  = (OPcode == c_OP_RTYPE);
    assign w_is_branch = (OPcode == c_OP_BRANCH);
    assign w_is_jal    = (OPcode == c_OP_JAL);
    assign w_is_jalr   = (OPcode == c_OP_JALR);
    assign w_is_lui    = c_UTYPE_EN && (OPcode == c_OP_LUI);
    assign w_is_auipc  = c_UTYPE_EN && (OPcode == c_OP_AUIPC);

    // Only beq (000) and bne (001) are supported branches.
    assign w_legal = w_is_load | w_is_ialu | w_is_store | w_is_rtype |
                     w_is_jal | w_is_jalr | w_is_lui | w_is_auipc |
                     (w_is_branch && (Fun3[2:1] == 2'b00));

    // A ready arriving on the last allowed cycle completes the access instead.
    assign w_timeout = (r_wait_cnt == c_WAIT_LAST) && !MIO_ready;

    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic f7,
                                          input logic allow_sub);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (allow_sub && f7) ? 4'b0110 : 4'b0010;
            3'b001:  op = 4'b0100;
            3'b010:  op = 4'b0111;
            3'b011:  op = 4'b1000;
            3'b100:  op = 4'b0011;
            3'b101:  op = f7 ? 4'b1101 : 4'b0101;
            3'b110:  op = 4'b0001;
            default: op = 4'b0000;
        endcase
        return op;
    endfunction

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_FETCH:  if (MIO_ready) w_next_state = c_DECODE;
                      else if (w_timeout) w_next_state = c_TRAP;
            c_DECODE: w_next_state = w_legal ? c_EXEC : c_TRAP;
            c_EXEC:   if (w_is_load || w_is_store) w_next_state = c_MEM;
                      else if (w_is_branch) w_next_state = c_FETCH;
                      else w_next_state = c_WB;
            c_MEM:    if (MIO_ready) w_next_state = w_is_load ? c_WB : c_FETCH;
                      else if (w_timeout) w_next_state = c_TRAP;
            c_WB:     w_next_state = c_FETCH;
            c_TRAP:   w_next_state = c_TRAP;
            default:  w_next_state = c_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_FETCH;
            r_wait_cnt   <= '0;
            r_trap       <= 1'b0;
            r_trap_cause <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state != r_state)
                r_wait_cnt <= '0;
            else if (((r_state == c_FETCH) || (r_state == c_MEM)) && !MIO_ready)
                r_wait_cnt <= r_wait_cnt + 1'b1;
            if ((w_next_state == c_TRAP) && (r_state != c_TRAP)) begin
                r_trap       <= 1'b1;
                // Traps taken from a memory phase are timeouts; DECODE traps are illegal opcodes.
                r_trap_cause <= (r_state == c_FETCH) || (r_state == c_MEM);
            end
        end
    end

    always_comb begin
        PCWrite     = 1'b0;
        IRWrite     = 1'b0;
        MemRead     = 1'b0;
        MemRW       = 1'b0;
        IorD        = 1'b0;
        RegWrite    = 1'b0;
        ALUSrc_B    = 1'b0;
        ImmSel      = 2'b00;
        MemtoReg    = 2'b00;
        PCSource    = 2'b00;
        ALU_Control = 4'b0010;
        case (r_state)
            c_FETCH: begin
                MemRead = !w_timeout;
                IRWrite = MIO_ready;
                PCWrite = MIO_ready;
            end
            c_EXEC: begin
                if (w_is_rtype) begin
                    ALU_Control = alu_op(Fun3, Fun7, 1'b1);
                end else if (w_is_ialu) begin
                    ALU_Control = alu_op(Fun3, Fun7, 1'b0);
                    ALUSrc_B    = 1'b1;
                end else if (w_is_load || w_is_jalr) begin
                    ALUSrc_B = 1'b1;
                end else if (w_is_store) begin
                    ALUSrc_B = 1'b1;
                    ImmSel   = 2'b01;
                end else if (w_is_branch) begin
                    ALU_Control = 4'b0110;
                    ImmSel      = 2'b10;
                    PCWrite     = Fun3[0] ? !Zero : Zero;
                    PCSource    = 2'b01;
                end else if (w_is_jal) begin
                    ImmSel = 2'b11;
                end else if (w_is_lui || w_is_auipc) begin
                    ImmSel   = 2'b11;
                    ALUSrc_B = 1'b1;
                end
            end
            c_MEM: begin
                IorD    = 1'b1;
                MemRead = w_is_load && !w_timeout;
                MemRW   = w_is_store && MIO_ready;
            end
            c_WB: begin
                RegWrite = 1'b1;
                if (w_is_load) begin
                    MemtoReg = 2'b01;
                end else if (w_is_jal || w_is_jalr) begin
                    MemtoReg = 2'b10;
                    PCWrite  = 1'b1;
                    PCSource = w_is_jal ? 2'b01 : 2'b10;
                end else if (w_is_lui) begin
                    MemtoReg = 2'b11;
                end
            end
            default: ;
        endcase
        if (!rst_n) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemRead  = 1'b0;
            MemRW    = 1'b0;
            RegWrite = 1'b0;
        end
    end

    assign state      = r_state;
    assign trap       = r_trap;
    assign trap_cause = r_trap_cause;

endmodule
`default_nettype wire

// File: tb/tb_mcpu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mcpu_ctrl
// Description : Directed self-checking bench for mcpu_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mcpu_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] OPcode = 5'b01100;
    logic [2:0] Fun3 = 3'b000;
    logic       Fun7 = 1'b0;
    logic       Zero = 1'b0;
    logic       MIO_ready = 1'b1;
    logic       PCWrite, IRWrite, MemRead, MemRW, IorD, RegWrite, ALUSrc_B;
    logic [1:0] ImmSel, MemtoReg, PCSource;
    logic [3:0] ALU_Control;
    logic [2:0] state;
    logic       trap, trap_cause;

    int n_checks = 0;
    int n_errors = 0;

    mcpu_ctrl #(.WAIT_LIMIT(16), .WAIT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .OPcode(OPcode), .Fun3(Fun3), .Fun7(Fun7),
        .Zero(Zero), .MIO_ready(MIO_ready), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .MemRead(MemRead), .MemRW(MemRW), .IorD(IorD), .RegWrite(RegWrite),
        .ALUSrc_B(ALUSrc_B), .ImmSel(ImmSel), .MemtoReg(MemtoReg),
        .PCSource(PCSource), .ALU_Control(ALU_Control), .state(state),
        .trap(trap), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        MIO_ready = 1'b1;
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic set_ir(input logic [4:0] op, input logic [2:0] f3, input logic f7);
        OPcode = op;
        Fun3   = f3;
        Fun7   = f7;
        #1;
    endtask

    // Runs one ALU-class instruction from FETCH through WB with memory always ready.
    task automatic run_alu(input string tag, input logic [4:0] op, input logic [2:0] f3,
                           input logic f7, input int exp_alu, input int exp_srcb);
        set_ir(op, f3, f7);
        chk({tag, "_fetch_irw"}, IRWrite, 1);
        step();
        chk({tag, "_dec_state"}, state, 1);
        step();
        chk({tag, "_exec_state"}, state, 2);
        chk({tag, "_alu"}, ALU_Control, exp_alu);
        chk({tag, "_srcb"}, ALUSrc_B, exp_srcb);
        chk({tag, "_exec_regw"}, RegWrite, 0);
        step();
        chk({tag, "_wb_state"}, state, 4);
        chk({tag, "_wb_regw"}, RegWrite, 1);
        chk({tag, "_wb_m2r"}, MemtoReg, 0);
        step();
        chk({tag, "_end_state"}, state, 0);
    endtask

    initial begin
        // Reset: strobes held low even though FETCH sees MIO_ready=1.
        rst_n = 1'b0;
        step();
        #1;
        chk("rst_state", state, 0);
        chk("rst_trap", trap, 0);
        chk("rst_cause", trap_cause, 0);
        chk("rst_strobes", {PCWrite, IRWrite, MemRead, MemRW, RegWrite}, 0);
        rst_n = 1'b1;
        #1;
        chk("fetch_memrd", MemRead, 1);
        chk("fetch_pcw", PCWrite, 1);
        chk("fetch_iord", IorD, 0);

        run_alu("add", 5'b01100, 3'b000, 1'b0, 4'b0010, 0);
        run_alu("sub", 5'b01100, 3'b000, 1'b1, 4'b0110, 0);
        run_alu("sra", 5'b01100, 3'b101, 1'b1, 4'b1101, 0);
        run_alu("sltu", 5'b01100, 3'b011, 1'b0, 4'b1000, 0);
        run_alu("srai", 5'b00100, 3'b101, 1'b1, 4'b1101, 1);
        run_alu("addi", 5'b00100, 3'b000, 1'b1, 4'b0010, 1);

        // lw with MEM stalled three cycles.
        set_ir(5'b00000, 3'b010, 1'b0);
        step(); step();
        chk("lw_exec_srcb", ALUSrc_B, 1);
        chk("lw_exec_alu", ALU_Control, 4'b0010);
        step();
        MIO_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lw_mem_state", state, 3);
            chk("lw_mem_rd", MemRead, 1);
            chk("lw_mem_iord", IorD, 1);
            step();
        end
        MIO_ready = 1'b1;
        #1;
        chk("lw_mem4_state", state, 3);
        step();
        chk("lw_wb_state", state, 4);
        chk("lw_wb_regw", RegWrite, 1);
        chk("lw_wb_m2r", MemtoReg, 1);
        step();
        chk("lw_end_state", state, 0);
        chk("lw_trap", trap, 0);

        // beq taken / not taken, bne taken.
        for (int k = 0; k < 3; k++) begin
            set_ir(5'b11000, (k == 2) ? 3'b001 : 3'b000, 1'b0);
            Zero = (k == 0);
            step(); step();
            #1;
            chk("br_exec_state", state, 2);
            chk("br_pcw", PCWrite, (k == 1) ? 0 : 1);
            chk("br_pcsrc", PCSource, 1);
            chk("br_alu", ALU_Control, 4'b0110);
            step();
            chk("br_end_state", state, 0);
        end

        // sw with one stalled MEM cycle.
        set_ir(5'b01000, 3'b010, 1'b0);
        step(); step();
        chk("sw_immsel", ImmSel, 1);
        step();
        MIO_ready = 1'b0;
        #1;
        chk("sw_stall_memrw", MemRW, 0);
        step();
        MIO_ready = 1'b1;
        #1;
        chk("sw_memrw", MemRW, 1);
        step();
        chk("sw_end_state", state, 0);

        // jal / jalr write-back.
        for (int k = 0; k < 2; k++) begin
            set_ir((k == 0) ? 5'b11011 : 5'b11001, 3'b000, 1'b0);
            step(); step(); step();
            chk("j_wb_state", state, 4);
            chk("j_wb_m2r", MemtoReg, 2);
            chk("j_wb_pcw", PCWrite, 1);
            chk("j_wb_pcsrc", PCSource, (k == 0) ? 1 : 2);
            step();
            chk("j_end_state", state, 0);
        end

        // FETCH timeout after 16 not-ready cycles.
        set_ir(5'b01100, 3'b000, 1'b0);
        MIO_ready = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            #1;
            chk("to_state", state, 0);
            chk("to_memrd", MemRead, (i == 16) ? 0 : 1);
            step();
        end
        chk("to_trap_state", state, 7);
        chk("to_trap", trap, 1);
        chk("to_cause", trap_cause, 1);
        MIO_ready = 1'b1;
        #1;
        chk("trap_strobes", {PCWrite, IRWrite, MemRead, MemRW, RegWrite}, 0);
        step();
        chk("trap_hold", state, 7);

        // Ready on the 16th cycle completes the fetch.
        do_reset();
        MIO_ready = 1'b0;
        for (int i = 1; i <= 15; i++) step();
        MIO_ready = 1'b1;
        #1;
        chk("late_irw", IRWrite, 1);
        step();
        chk("late_state", state, 1);
        chk("late_trap", trap, 0);

        // Illegal branch funct3 traps with cause 0.
        do_reset();
        set_ir(5'b11000, 3'b100, 1'b0);
        step(); step();
        chk("blt_state", state, 7);
        chk("blt_cause", trap_cause, 0);

        // lui.
        do_reset();
        set_ir(5'b01101, 3'b000, 1'b0);
        step(); step();
`ifdef MCPU_UTYPE_EN
        chk("lui_exec", state, 2);
        step();
        chk("lui_regw", RegWrite, 1);
        chk("lui_m2r", MemtoReg, 3);
`else
        chk("lui_state", state, 7);
        chk("lui_trap", trap, 1);
        chk("lui_cause", trap_cause, 0);
`endif

        // Reset during MEM of sw.
        do_reset();
        set_ir(5'b01000, 3'b010, 1'b0);
        step(); step(); step();
        chk("swrst_mem_state", state, 3);
        rst_n = 1'b0;
        #1;
        chk("swrst_memrw", MemRW, 0);
        step();
        chk("swrst_state", state, 0);
        chk("swrst_trap", trap, 0);
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
